alu_operand_sequencer: RTL and testbench
========================================

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 SHALL have parameter BUS_LEN, default 8, operand/result width (>=4).
REQ-002 SHALL have parameter OPCODE_LEN, default 6, opcode width taken from switches[OPCODE_LEN-1:0] (OPCODE_LEN<=BUS_LEN).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4, stable-cycle count for button acceptance (>=1).
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 input_rst  input  1  asynchronous active-high reset.
REQ-007 buttonA  input  1  raw (bouncing, asynchronous) load-A button.
REQ-008 buttonB  input  1  raw load-B button.
REQ-009 button_opcode  input  1  raw load-opcode button.
REQ-010 switches  input  BUS_LEN  operand/opcode source.
REQ-011 leds  output  BUS_LEN  registered result.
REQ-012 flags  output  4  registered {err, overflow, carry, zero}, bit 3 = err.
REQ-013 state  output  2  current FSM state encoding.
REQ-014 result_valid  output  1  high while leds holds a result for the current operand set.

Function
REQ-015 Each button SHALL pass a 2-flop synchroniser, then a debouncer: debounced level changes only after synchroniser output differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to equality clears the counter.
REQ-016 A press pulse SHALL be one cycle wide, on debounced 0->1 only; raw input held high from edge k yields pulse in cycle k+2+DEBOUNCE_CYCLES.
REQ-017 FSM states SHALL be WAIT_A=0, WAIT_B=1, WAIT_OP=2, SHOW=3.
REQ-018 WAIT_A: A pulse loads A<=switches, go WAIT_B; B/opcode pulses ignored.
REQ-019 WAIT_B: B pulse loads B<=switches, go WAIT_OP; other pulses ignored.
REQ-020 WAIT_OP: opcode pulse loads opcode<=switches[OPCODE_LEN-1:0], go SHOW; others ignored.
REQ-021 leds/flags SHALL update on the edge after opcode load (1-cycle latency), result_valid rising the same edge.
REQ-022 SHOW: A pulse loads A, go WAIT_B, result_valid<=0, leds/flags hold old values; B/opcode pulses ignored.
REQ-023 Simultaneous pulses: only the pulse matching current state acts; others discarded, not queued.
REQ-024 Opcodes: ADD 6'b100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRL 000010 (A>>B), SRA 000011 (A>>>B signed).
REQ-025 ADD/SUB SHALL be BUS_LEN-bit modulo; carry = ADD carry-out or SUB borrow (A<B unsigned); overflow = two's-complement signed overflow; both 0 for other ops.
REQ-026 Shift amount = B unsigned; B>=BUS_LEN gives SRL 0, SRA all copies of A[MSB].
REQ-027 zero SHALL be 1 iff result==0.
REQ-028 Unknown opcode: leds=0, err=1, zero=1, carry=overflow=0; err=0 for valid opcodes.
REQ-029 With OPCODE_LEN>6, opcode bits above 5 SHALL be zero for a valid opcode, else unknown.

Reset
REQ-030 input_rst high SHALL immediately force state=WAIT_A, A=B=opcode=0, leds=0, flags=0, result_valid=0, synchronisers/debounced levels/counters=0.
REQ-031 Reset mid-operation SHALL discard partial loads; no pulse SHALL be generated while input_rst high.
REQ-032 A button held across reset deassertion SHALL register as one press per REQ-016 timing after deassertion.

Verification (BUS_LEN=8, DEBOUNCE_CYCLES=4)
REQ-033 Reset; load A=0x05, B=0x03, op=0x20 -> leds=0x08, flags=0000, result_valid=1, state=3, one cycle after opcode pulse.
REQ-034 A=0x7F, B=0x01, ADD -> leds=0x80, flags=0100; A=0xFF, B=0x01, ADD -> leds=0x00, flags=0011.
REQ-035 A=0x03, B=0x05, SUB -> leds=0xFE, flags=0010; A=0x80, B=0x09, SRA -> leds=0xFF; op=0x3F -> leds=0x00, flags=1001.
REQ-036 buttonA toggled every 2 cycles for 20 cycles in WAIT_A -> no pulse, A=0, state=0; then held 8 cycles -> exactly one pulse in cycle k+6, state=1.
REQ-037 buttonB and button_opcode pressed in WAIT_A -> no loads; input_rst pulsed in WAIT_OP -> state=0, leds=0, result_valid=0 before next clk edge.
REQ-038 In SHOW, A pulse -> state=1, result_valid=0, leds unchanged until next opcode load.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Button-driven ALU front end: three debounced buttons step an FSM that latches
// operand A, operand B and an opcode from the switches, then shows the result.
module alu_operand_sequencer #(
  parameter int BUS_LEN         = 8,
  parameter int OPCODE_LEN      = 6,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               input_rst,
  input  logic               buttonA,
  input  logic               buttonB,
  input  logic               button_opcode,
  input  logic [BUS_LEN-1:0] switches,
  output logic [BUS_LEN-1:0] leds,
  output logic [3:0]         flags,
  output logic [1:0]         state,
  output logic               result_valid
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int OPW = (OPCODE_LEN > 6) ? OPCODE_LEN : 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {button_opcode, buttonB, buttonA};

  // Per button: 2-flop synchroniser, then a level debouncer whose one-cycle
  // press pulse is registered so the FSM sees it on the following edge.
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic          sync1_q, sync2_q, deb_q, pulse_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge input_rst) begin
      if (input_rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        pulse_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= btn_raw[gi];
        sync2_q <= sync1_q;
        pulse_q <= 1'b0;
        if (sync2_q != deb_q) begin
          if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb_q   <= sync2_q;
            cnt_q   <= '0;
            pulse_q <= sync2_q;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end

    assign press[gi] = pulse_q;
  end

  state_t                state_q, state_d;
  logic [BUS_LEN-1:0]    a_q, a_d, b_q, b_d;
  logic [OPCODE_LEN-1:0] op_q, op_d;
  logic                  pend_q, pend_d;
  logic [BUS_LEN-1:0]    leds_q, leds_d;
  logic [3:0]            flags_q, flags_d;
  logic                  valid_q, valid_d;

  logic [OPW-1:0]        op_ext;
  logic [BUS_LEN:0]      sum;
  logic [BUS_LEN-1:0]    diff, sra_res, alu_res;
  logic                  big_shift, alu_c, alu_v, alu_err;

  // Upper opcode bits beyond the 6-bit field must be zero, which the
  // zero-extended compare below enforces for free.
  assign op_ext    = OPW'(op_q);
  assign big_shift = (b_q >= BUS_LEN'(BUS_LEN));
  assign sra_res   = BUS_LEN'($signed(a_q) >>> b_q);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = a_q - b_q;
    case (op_ext)
      OPW'(OP_ADD): begin
        alu_res = sum[BUS_LEN-1:0];
        alu_c   = sum[BUS_LEN];
        alu_v   = (a_q[BUS_LEN-1] == b_q[BUS_LEN-1]) && (sum[BUS_LEN-1] != a_q[BUS_LEN-1]);
      end
      OPW'(OP_SUB): begin
        alu_res = diff;
        alu_c   = (a_q < b_q);
        alu_v   = (a_q[BUS_LEN-1] != b_q[BUS_LEN-1]) && (diff[BUS_LEN-1] != a_q[BUS_LEN-1]);
      end
      OPW'(OP_AND): alu_res = a_q & b_q;
      OPW'(OP_OR):  alu_res = a_q | b_q;
      OPW'(OP_XOR): alu_res = a_q ^ b_q;
      OPW'(OP_NOR): alu_res = ~(a_q | b_q);
      OPW'(OP_SRL): alu_res = big_shift ? '0 : (a_q >> b_q);
      OPW'(OP_SRA): alu_res = big_shift ? {BUS_LEN{a_q[BUS_LEN-1]}} : sra_res;
      default:      alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    pend_d  = 1'b0;
    leds_d  = leds_q;
    flags_d = flags_q;
    valid_d = valid_q;
    case (state_q)
      WAIT_A: if (press[0]) begin
        a_d     = switches;
        state_d = WAIT_B;
      end
      WAIT_B: if (press[1]) begin
        b_d     = switches;
        state_d = WAIT_OP;
      end
      WAIT_OP: if (press[2]) begin
        op_d    = switches[OPCODE_LEN-1:0];
        state_d = SHOW;
        pend_d  = 1'b1;
      end
      SHOW: if (press[0]) begin
        a_d     = switches;
        state_d = WAIT_B;
        valid_d = 1'b0;
      end
      default: state_d = WAIT_A;
    endcase
    // Result is captured one edge after the opcode so it sees the loaded opcode.
    if (pend_q) begin
      leds_d  = alu_res;
      flags_d = {alu_err, alu_v, alu_c, (alu_res == '0)};
      valid_d = (state_d == SHOW);
    end
  end

  always_ff @(posedge clk or posedge input_rst) begin
    if (input_rst) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      pend_q  <= 1'b0;
      leds_q  <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
      leds_q  <= leds_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
    end
  end

  assign leds         = leds_q;
  assign flags        = flags_q;
  assign state        = state_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench: operand/opcode presses queue the expected {leds,flags};
// a monitor pops and compares on every rising edge of result_valid.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       input_rst = 1'b1;
  logic       buttonA = 1'b0, buttonB = 1'b0, button_opcode = 1'b0;
  logic [7:0] switches = 8'h00;
  logic [7:0] leds;
  logic [3:0] flags;
  logic [1:0] state;
  logic       result_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [11:0] exp_q[$];

  alu_operand_sequencer #(.BUS_LEN(8), .OPCODE_LEN(6), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .input_rst(input_rst), .buttonA(buttonA), .buttonB(buttonB),
    .button_opcode(button_opcode), .switches(switches), .leds(leds),
    .flags(flags), .state(state), .result_valid(result_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: compare every fresh result against the head of the scoreboard.
  initial begin
    logic        rv_prev;
    logic [1:0]  st_prev;
    int          show_cyc;
    logic [11:0] e;
    rv_prev  = 1'b0;
    st_prev  = 2'd0;
    show_cyc = -100;
    forever begin
      @(negedge clk);
      if (st_prev == 2'd2 && state == 2'd3) show_cyc = cyc;
      if (result_valid && !rv_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result_leds", leds, e[11:4]);
          check("result_flags", flags, e[3:0]);
          check("result_latency", cyc - show_cyc, 1);
        end
      end
      rv_prev = result_valid;
      st_prev = state;
    end
  end

  task automatic press(input int which, input logic [7:0] sw);
    @(negedge clk);
    switches = sw;
    case (which)
      0: buttonA = 1'b1;
      1: buttonB = 1'b1;
      default: button_opcode = 1'b1;
    endcase
    repeat (10) @(negedge clk);
    buttonA = 1'b0;
    buttonB = 1'b0;
    button_opcode = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                        input logic [7:0] el, input logic [3:0] ef);
    logic       was_show;
    logic [7:0] old_leds;
    was_show = (state == 2'd3);
    old_leds = leds;
    press(0, a);
    if (was_show) begin
      check("show_A_state", state, 2'd1);
      check("show_A_valid", result_valid, 1'b0);
      check("show_A_leds_hold", leds, old_leds);
    end else begin
      check("load_A_state", state, 2'd1);
    end
    press(1, b);
    check("load_B_state", state, 2'd2);
    if (was_show) check("leds_hold_wait_op", leds, old_leds);
    exp_q.push_back({el, ef});
    press(2, op);
    check("op_state", state, 2'd3);
    check("op_valid", result_valid, 1'b1);
  endtask

  initial begin
    logic bad_seen;
    repeat (3) @(negedge clk);
    check("rst_state", state, 2'd0);
    check("rst_leds", leds, 8'h00);
    check("rst_flags", flags, 4'h0);
    check("rst_valid", result_valid, 1'b0);
    input_rst = 1'b0;
    repeat (3) @(negedge clk);

    run_op(8'h05, 8'h03, 8'h20, 8'h08, 4'b0000);
    run_op(8'h7F, 8'h01, 8'h20, 8'h80, 4'b0100);
    run_op(8'hFF, 8'h01, 8'h20, 8'h00, 4'b0011);
    run_op(8'h03, 8'h05, 8'h22, 8'hFE, 4'b0010);
    run_op(8'h80, 8'h01, 8'h22, 8'h7F, 4'b0100);
    run_op(8'h80, 8'h09, 8'h03, 8'hFF, 4'b0000);
    run_op(8'h80, 8'h09, 8'h02, 8'h00, 4'b0001);
    run_op(8'h80, 8'h03, 8'h02, 8'h10, 4'b0000);
    run_op(8'h80, 8'h03, 8'h03, 8'hF0, 4'b0000);
    run_op(8'hF0, 8'h3C, 8'h24, 8'h30, 4'b0000);
    run_op(8'h0F, 8'h30, 8'h25, 8'h3F, 4'b0000);
    run_op(8'h0F, 8'hF0, 8'h27, 8'h00, 4'b0001);
    run_op(8'h12, 8'h34, 8'h3F, 8'h00, 4'b1001);
    run_op(8'hAA, 8'h55, 8'h26, 8'hFF, 4'b0000);

    // Asynchronous reset in WAIT_OP takes effect before the next edge.
    press(0, 8'h11);
    press(1, 8'h22);
    check("pre_rst_state", state, 2'd2);
    @(posedge clk);
    #2 input_rst = 1'b1;
    #1;
    check("async_rst_state", state, 2'd0);
    check("async_rst_leds", leds, 8'h00);
    check("async_rst_flags", flags, 4'h0);
    check("async_rst_valid", result_valid, 1'b0);
    repeat (3) @(negedge clk);
    input_rst = 1'b0;
    repeat (3) @(negedge clk);

    // B and opcode together in WAIT_A must be ignored.
    buttonB = 1'b1;
    button_opcode = 1'b1;
    repeat (10) @(negedge clk);
    buttonB = 1'b0;
    button_opcode = 1'b0;
    repeat (10) @(negedge clk);
    check("wait_a_ignores_b_op", state, 2'd0);

    // Bouncing A (toggle every 2 cycles) never qualifies.
    bad_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      buttonA = ~buttonA;
      repeat (2) begin
        @(negedge clk);
        if (state != 2'd0) bad_seen = 1'b1;
      end
    end
    buttonA = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_no_load", bad_seen, 1'b0);
    check("bounce_state", state, 2'd0);

    // Steady A from edge k: state must change exactly at edge k+6.
    buttonA = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("hold_before_k6", state, 2'd0);
    @(posedge clk);
    #1 check("hold_at_k6", state, 2'd1);
    repeat (3) @(negedge clk);
    buttonA = 1'b0;
    repeat (10) @(negedge clk);
    check("hold_after_release", state, 2'd1);

    // Button held across reset deassertion registers as one press afterwards.
    input_rst = 1'b1;
    buttonA = 1'b1;
    repeat (4) @(negedge clk);
    check("held_rst_state", state, 2'd0);
    input_rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("held_rst_before_k6", state, 2'd0);
    @(posedge clk);
    #1 check("held_rst_at_k6", state, 2'd1);
    @(negedge clk);
    buttonA = 1'b0;
    repeat (10) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
